// File: rtl/mux_sel_arbiter_4_pkg.sv
// mux_arb_pkg: shared widths, arbiter state type and one-hot helper
package mux_arb_pkg;
  localparam int N_CH  = 4;
  localparam int SEL_W = 2;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic logic [N_CH-1:0] onehot(input logic [SEL_W-1:0] i);
    return N_CH'(1) << i;
  endfunction
endpackage

// File: rtl/mux_sel_arbiter_4_if.sv
// mux_sel_arbiter_4_if: request/select/handshake bundle between arbiter and its environment
// master: arbiter side (takes req/out_ready, drives sel/grant/out_valid/busy); slave: environment side
interface mux_sel_arbiter_4_if;
  import mux_arb_pkg::*;
  logic [N_CH-1:0]  req;
  logic             out_ready;
  logic [SEL_W-1:0] sel;
  logic [N_CH-1:0]  grant;
  logic             out_valid;
  logic             busy;
  modport master(input req, out_ready, output sel, grant, out_valid, busy);
  modport slave(output req, out_ready, input sel, grant, out_valid, busy);
endinterface

// File: rtl/mux_sel_arbiter_4_rr_pick.sv
// rr_pick_4: first set request at or after ptr, wrapping mod 4
// req: requests, ptr: highest-priority channel, pick: chosen channel, found: any request set
module rr_pick_4
  import mux_arb_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] pick,
  output logic             found
);
  logic [N_CH-1:0]  rot;
  logic [SEL_W-1:0] off;
  always_comb begin
    rot   = N_CH'({req, req} >> ptr);
    off   = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    pick  = ptr + off;
    found = |req;
  end
endmodule

// File: rtl/mux_sel_arbiter_4.sv
// mux_sel_arbiter_4: round-robin arbiter driving a 4:1 mux select with bounded bursts
// clk/rst: clock and sync active-high reset; bus: req/out_ready in, sel/grant/out_valid/busy out
module mux_sel_arbiter_4
  import mux_arb_pkg::*;
#(
  parameter int MAX_BURST = 1
) (
  input logic clk,
  input logic rst,
  mux_sel_arbiter_4_if.master bus
);
  localparam int CW = $clog2(MAX_BURST + 1);
  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d, ptr_q, ptr_d, pick, pick_ptr;
  logic [N_CH-1:0]  grant_q, grant_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, found, idle, xfer, rel, load;
  rr_pick_4 u_pick (.req(bus.req), .ptr(pick_ptr), .pick(pick), .found(found));
  assign bus.out_valid = (state_q == GRANT) & bus.req[sel_q];
  assign bus.sel       = sel_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;
  // Release re-picks in the same cycle starting just after the current channel, so there is no bubble.
  always_comb begin
    idle     = state_q == IDLE;
    xfer     = bus.out_valid & bus.out_ready;
    rel      = !idle & (!bus.req[sel_q] | (xfer & (cnt_q == CW'(MAX_BURST - 1))));
    pick_ptr = idle ? ptr_q : sel_q + SEL_W'(1);
    load     = (idle | rel) & found;
    ptr_d    = rel ? sel_q + SEL_W'(1) : ptr_q;
    state_d  = load ? GRANT : rel ? IDLE : state_q;
    sel_d    = load ? pick : sel_q;
    grant_d  = load ? onehot(pick) : rel ? '0 : grant_q;
    busy_d   = load ? 1'b1 : rel ? 1'b0 : busy_q;
    cnt_d    = (load | rel) ? '0 : xfer ? cnt_q + CW'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end
endmodule
